// File: rtl/led_mode_player.sv
// LED pattern player: maps the 3-bit mode index to one of eight timed LED patterns.
// Pattern steps come from a shared prescaler; mode 7 is a PWM breathing effect.
module led_mode_player #(
  parameter int unsigned TICK_CNT   = 25_000_000,
  parameter int unsigned BREATH_DIV = 195_312
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic [2:0] mode,
  output logic [7:0] led,
  output logic       step_tick
);

  localparam int unsigned TW = $clog2(TICK_CNT);
  localparam int unsigned BW = $clog2(BREATH_DIV);

  typedef enum logic [2:0] {
    M_OFF     = 3'd0,
    M_ON      = 3'd1,
    M_RUN_L   = 3'd2,
    M_RUN_R   = 3'd3,
    M_BLINK   = 3'd4,
    M_PING    = 3'd5,
    M_COUNT   = 3'd6,
    M_BREATHE = 3'd7
  } mode_t;

  mode_t         mode_q, mode_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [BW-1:0] bdiv_q, bdiv_d;
  logic [7:0]    pc_q, pc_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    led_d;
  logic          dir_q, dir_d;   // 0 = left / rising, 1 = right / falling
  logic          tick_d;
  logic          change, tc, bstep;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= M_OFF;
      presc_q   <= '0;
      bdiv_q    <= '0;
      pc_q      <= '0;
      duty_q    <= '0;
      dir_q     <= 1'b0;
      led       <= '0;
      step_tick <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      bdiv_q    <= bdiv_d;
      pc_q      <= pc_d;
      duty_q    <= duty_d;
      dir_q     <= dir_d;
      led       <= led_d;
      step_tick <= tick_d;
    end
  end

  always_comb begin
    change  = (mode != mode_q);
    tc      = (presc_q == TW'(TICK_CNT - 1));
    bstep   = (bdiv_q == BW'(BREATH_DIV - 1));
    mode_d  = mode_q;
    presc_d = tc ? '0 : presc_q + TW'(1);
    bdiv_d  = bstep ? '0 : bdiv_q + BW'(1);
    pc_d    = pc_q + 8'd1;
    duty_d  = duty_q;
    dir_d   = dir_q;
    led_d   = led;
    tick_d  = tc;

    if (change) begin
      // A mode change wins over a coincident tick: restart timing and load the init pattern.
      mode_d  = mode_t'(mode);
      presc_d = '0;
      bdiv_d  = '0;
      pc_d    = '0;
      duty_d  = '0;
      dir_d   = 1'b0;
      tick_d  = 1'b0;
      case (mode_t'(mode))
        M_ON, M_BLINK:   led_d = 8'hFF;
        M_RUN_L, M_PING: led_d = 8'h01;
        M_RUN_R:         led_d = 8'h80;
        default:         led_d = 8'h00;
      endcase
    end else if (mode_q == M_BREATHE) begin
      if (bstep) begin
        if (!dir_q) begin
          duty_d = (duty_q == 8'hFF) ? 8'hFE : duty_q + 8'd1;
          dir_d  = (duty_q == 8'hFF);
        end else begin
          duty_d = (duty_q == 8'h00) ? 8'h01 : duty_q - 8'd1;
          dir_d  = (duty_q != 8'h00);
        end
      end
      led_d = {8{pc_d < duty_d}};
    end else if (tc) begin
      case (mode_q)
        M_RUN_L: led_d = {led[6:0], led[7]};
        M_RUN_R: led_d = {led[0], led[7:1]};
        M_BLINK: led_d = ~led;
        M_COUNT: led_d = led + 8'd1;
        M_PING: begin
          if (!dir_q) begin
            if (led == 8'h80) begin
              led_d = 8'h40;
              dir_d = 1'b1;
            end else begin
              led_d = {led[6:0], 1'b0};
            end
          end else begin
            if (led == 8'h01) begin
              led_d = 8'h02;
              dir_d = 1'b0;
            end else begin
              led_d = {1'b0, led[7:1]};
            end
          end
        end
        default: led_d = led;
      endcase
    end
  end

endmodule
